// File: rtl/el2_pkg.sv
// Shared types for the EL2 retirement trace consumer.
//   el2_trace_pkt_t  : 104-bit retirement trace packet driven by the core
//   el2_trace_type_t : record type carried in the beat header
//   el2_trace_rec_t  : one buffered trace record (FIFO payload)
// Optional feature macro: EL2_TRACE_TS_EN (adds a 32-bit timestamp to each
// record and a TS beat after the header).
package el2_pkg;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  typedef enum logic [1:0] {
    EL2_TRACE_NORM = 2'b00,
    EL2_TRACE_EXC  = 2'b01,
    EL2_TRACE_INT  = 2'b10,
    EL2_TRACE_OVF  = 2'b11
  } el2_trace_type_t;

  localparam logic [3:0] EL2_TRACE_SYNC = 4'hA;

`ifdef EL2_TRACE_TS_EN
  localparam logic [2:0] EL2_TRACE_TS_BEATS = 3'd1;
`else
  localparam logic [2:0] EL2_TRACE_TS_BEATS = 3'd0;
`endif

  // seq holds the sequence number, or the drop count for OVF markers
  typedef struct packed {
    el2_trace_type_t rtype;
    logic [4:0]      ecause;
    logic [31:0]     addr;
    logic [31:0]     insn;
    logic [31:0]     tval;
    logic [15:0]     seq;
`ifdef EL2_TRACE_TS_EN
    logic [31:0]     ts;
`endif
  } el2_trace_rec_t;

  // Total beats per record, header included
  function automatic logic [2:0] el2_trace_beats(el2_trace_type_t t);
    logic [2:0] n;
    case (t)
      EL2_TRACE_NORM: n = 3'd3;
      EL2_TRACE_EXC,
      EL2_TRACE_INT:  n = 3'd4;
      default:        n = 3'd1;
    endcase
    return n + EL2_TRACE_TS_BEATS;
  endfunction

endpackage

// File: rtl/el2_trace_fifo.sv
// Synchronous FIFO of trace records.
//   clk, rst     : clock, async active-high reset
//   push, wdata  : write request and record (ignored when full)
//   pop, rdata   : read request and head record (ignored when empty)
//   full, empty, count : occupancy status
module el2_trace_fifo
  import el2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  el2_trace_rec_t wdata,
  input  logic           pop,
  output el2_trace_rec_t rdata,
  output logic           full,
  output logic           empty,
  output logic [CW-1:0]  count
);

  el2_trace_rec_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/el2_trace_port.sv
// Retirement trace consumer: captures el2_trace_pkt_t packets into a FIFO
// and serializes each record into 32-bit beats on a valid/ready port.
// Drops on overflow and later queues an OVF marker carrying the drop count.
//   clk, rst   : clock, async active-high reset
//   trace_en   : capture enable
//   trace_pkt  : retirement trace packet
//   tx_data, tx_valid, tx_ready : beat output handshake
//   drop_cnt   : drops since the last marker was queued (saturating)
//   busy       : FIFO non-empty or serializer active
// Optional feature macro: EL2_TRACE_TS_EN (timestamp beat after header).
module el2_trace_port
  import el2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           trace_en,
  input  el2_trace_pkt_t trace_pkt,
  output logic [31:0]    tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [15:0]    drop_cnt,
  output logic           busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef EL2_TRACE_TS_EN
  typedef enum logic [2:0] {
    TP_IDLE, TP_HDR, TP_TS, TP_ADDR, TP_INSN, TP_TVAL
  } tp_state_t;
  logic [31:0] ts_q;
`else
  typedef enum logic [2:0] {
    TP_IDLE, TP_HDR, TP_ADDR, TP_INSN, TP_TVAL
  } tp_state_t;
`endif

  tp_state_t      state_q, state_d;
  logic           ovf_pending;
  logic [SEQ_W-1:0] seq_q;
  logic [15:0]    drop_inc;
  logic           pkt_v;
  logic           push;
  logic           pop;
  logic           hs;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  el2_trace_rec_t push_rec;
  el2_trace_rec_t head;

  assign pkt_v    = trace_en & trace_pkt.trace_rv_i_valid_ip;
  assign push     = pkt_v & ~fifo_full;
  assign drop_inc = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
  assign tx_valid = (state_q != TP_IDLE);
  assign hs       = tx_valid & tx_ready;
  assign busy     = ~fifo_empty | tx_valid;

  // Record to queue: OVF marker if one is owed, else the packet itself
  always_comb begin
    push_rec = '0;
    if (ovf_pending) begin
      push_rec.rtype = EL2_TRACE_OVF;
      push_rec.seq   = drop_inc;
    end else begin
      if (trace_pkt.trace_rv_i_interrupt_ip)      push_rec.rtype = EL2_TRACE_INT;
      else if (trace_pkt.trace_rv_i_exception_ip) push_rec.rtype = EL2_TRACE_EXC;
      else                                        push_rec.rtype = EL2_TRACE_NORM;
      if (push_rec.rtype != EL2_TRACE_NORM)
        push_rec.ecause = trace_pkt.trace_rv_i_ecause_ip;
      push_rec.addr = trace_pkt.trace_rv_i_address_ip;
      push_rec.insn = trace_pkt.trace_rv_i_insn_ip;
      push_rec.tval = trace_pkt.trace_rv_i_tval_ip;
      push_rec.seq  = 16'(seq_q);
    end
`ifdef EL2_TRACE_TS_EN
    push_rec.ts = ts_q;
`endif
  end

  // Capture bookkeeping: drop counting, marker owed, sequence number
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt    <= '0;
      ovf_pending <= 1'b0;
      seq_q       <= '0;
    end else if (pkt_v) begin
      if (fifo_full) begin
        drop_cnt    <= drop_inc;
        ovf_pending <= 1'b1;
      end else if (ovf_pending) begin
        drop_cnt    <= '0;
        ovf_pending <= 1'b0;
      end else begin
        seq_q <= seq_q + SEQ_W'(1);
      end
    end
  end

`ifdef EL2_TRACE_TS_EN
  // Free-running cycle counter sampled into each record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end
`endif

  el2_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TP_IDLE;
    else     state_q <= state_d;
  end

  // Serializer next state; the head record is popped on its last beat
  always_comb begin
    logic      last_beat;
    tp_state_t nxt_beat;
    state_d   = state_q;
    pop       = 1'b0;
    last_beat = 1'b0;
    nxt_beat  = TP_IDLE;
    case (state_q)
      TP_HDR: begin
`ifdef EL2_TRACE_TS_EN
        nxt_beat = TP_TS;
`else
        last_beat = (head.rtype == EL2_TRACE_OVF);
        nxt_beat  = TP_ADDR;
`endif
      end
`ifdef EL2_TRACE_TS_EN
      TP_TS: begin
        last_beat = (head.rtype == EL2_TRACE_OVF);
        nxt_beat  = TP_ADDR;
      end
`endif
      TP_ADDR: nxt_beat = TP_INSN;
      TP_INSN: begin
        last_beat = (head.rtype == EL2_TRACE_NORM);
        nxt_beat  = TP_TVAL;
      end
      TP_TVAL: last_beat = 1'b1;
      default: ;
    endcase

    if (state_q == TP_IDLE) begin
      if (!fifo_empty) state_d = TP_HDR;
    end else if (hs) begin
      if (last_beat) begin
        pop = 1'b1;
        // Post-pop occupancy, counting a same-cycle push
        state_d = ((fifo_count > CW'(1)) || push) ? TP_HDR : TP_IDLE;
      end else begin
        state_d = nxt_beat;
      end
    end
  end

  // Beat data from current state and head record; stable while stalled
  always_comb begin
    tx_data = '0;
    case (state_q)
      TP_HDR:  tx_data = {EL2_TRACE_SYNC, head.rtype, head.ecause,
                          el2_trace_beats(head.rtype), 2'b00, head.seq};
`ifdef EL2_TRACE_TS_EN
      TP_TS:   tx_data = head.ts;
`endif
      TP_ADDR: tx_data = head.addr;
      TP_INSN: tx_data = head.insn;
      TP_TVAL: tx_data = head.tval;
      default: tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_el2_trace_port.sv
// Self-checking bench for el2_trace_port (default build, no timestamp beat).
module tb_el2_trace_port;
  import el2_pkg::*;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           trace_en;
  el2_trace_pkt_t trace_pkt;
  logic [31:0]    tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [15:0]    drop_cnt;
  logic           busy;

  always #5 clk = ~clk;

  el2_trace_port #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_en  (trace_en),
    .trace_pkt (trace_pkt),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit [1:0]  typ;
    bit [4:0]  ec;
    bit [31:0] addr;
    bit [31:0] insn;
    bit [31:0] tval;
    bit [15:0] seq;
  } mrec_t;

  mrec_t       mq[$];
  int          m_idx;
  bit          m_active;
  bit [15:0]   m_drop;
  bit          m_ovf;
  int unsigned m_seq;

  function automatic int nbeats(bit [1:0] t);
    if (t == 2'd3) return 1;
    if (t == 2'd0) return 3;
    return 4;
  endfunction

  function automatic bit [31:0] beat(mrec_t r, int k);
    bit [31:0] h;
    h = 32'hA000_0000 + (32'(r.typ) << 26) + (32'(r.ec) << 21)
      + (32'(nbeats(r.typ)) << 18) + 32'(r.seq);
    case (k)
      0:       return h;
      1:       return r.addr;
      2:       return r.insn;
      default: return r.tval;
    endcase
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_idx = 0; m_active = 0; m_drop = 0; m_ovf = 0; m_seq = 0;
  endfunction

  // Advance the model by one clock edge using the inputs of that cycle
  function automatic void model_update();
    int    size0;
    bit    hs;
    bit    last;
    mrec_t r;
    if (rst) begin
      model_reset();
      return;
    end
    size0 = mq.size();
    hs    = m_active && tx_ready;
    last  = hs && (m_idx + 1 == nbeats(mq[0].typ));
    if (trace_en && trace_pkt.trace_rv_i_valid_ip) begin
      if (size0 == DEPTH) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_ovf = 1;
      end else if (m_ovf) begin
        r.typ = 2'd3; r.ec = 0; r.addr = 0; r.insn = 0; r.tval = 0;
        r.seq = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
        mq.push_back(r);
        m_drop = 0;
        m_ovf  = 0;
      end else begin
        r.typ  = trace_pkt.trace_rv_i_interrupt_ip ? 2'd2 :
                 trace_pkt.trace_rv_i_exception_ip ? 2'd1 : 2'd0;
        r.ec   = (r.typ == 2'd0) ? 5'd0 : trace_pkt.trace_rv_i_ecause_ip;
        r.addr = trace_pkt.trace_rv_i_address_ip;
        r.insn = trace_pkt.trace_rv_i_insn_ip;
        r.tval = trace_pkt.trace_rv_i_tval_ip;
        r.seq  = 16'(m_seq);
        mq.push_back(r);
        m_seq = (m_seq + 1) % (1 << SEQ_W);
      end
    end
    if (m_active) begin
      if (hs) begin
        if (last) begin
          void'(mq.pop_front());
          m_idx    = 0;
          m_active = (mq.size() > 0);
        end else begin
          m_idx++;
        end
      end
    end else begin
      m_active = (size0 > 0);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  int          cyc = 0;
  logic [31:0] cap[$];
  int          cap_cyc[$];

  function automatic logic [31:0] capk(int k);
    if (k < cap.size()) return cap[k];
    return 'x;
  endfunction

  // One clock: compare outputs on the falling edge, then step the model
  task automatic cycle();
    @(negedge clk);
    check("tx_valid", 32'(tx_valid), 32'(m_active));
    if (m_active) check("tx_data", tx_data, beat(mq[0], m_idx));
    check("busy", 32'(busy), 32'(m_active || (mq.size() > 0)));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (tx_valid && tx_ready) begin
      cap.push_back(tx_data);
      cap_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic set_pkt(bit v, bit exc, bit intr, bit [4:0] ec,
                         bit [31:0] a, bit [31:0] i, bit [31:0] t);
    trace_pkt.trace_rv_i_valid_ip     = v;
    trace_pkt.trace_rv_i_exception_ip = exc;
    trace_pkt.trace_rv_i_interrupt_ip = intr;
    trace_pkt.trace_rv_i_ecause_ip    = ec;
    trace_pkt.trace_rv_i_address_ip   = a;
    trace_pkt.trace_rv_i_insn_ip      = i;
    trace_pkt.trace_rv_i_tval_ip      = t;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    trace_en  = 1'b0;
    tx_ready  = 1'b0;
    trace_pkt = '0;
    model_reset();
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap.delete();
    cap_cyc.delete();
  endtask

  task automatic run_until_idle(int maxc);
    int k = 0;
    while ((m_active || mq.size() > 0) && k < maxc) begin
      cycle();
      k++;
    end
    if (k == maxc) check("idle_timeout", 32'd1, 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit        exc;
    bit        intr;
    bit [4:0]  ec;
    bit [31:0] addr;
    bit [31:0] insn;
    bit [31:0] tval;
    bit [31:0] exp_hdr;
    int        exp_n;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int pc;
    int k;
    tbl[0] = '{exc:0, intr:0, ec:5'd0,  addr:32'h8000_0010, insn:32'h0000_0013,
               tval:32'h0, exp_hdr:32'hA00C_0000, exp_n:3};
    tbl[1] = '{exc:1, intr:0, ec:5'd2,  addr:32'h8000_0014, insn:32'h0000_0073,
               tval:32'hDEAD_BEEF, exp_hdr:32'hA450_0001, exp_n:4};
    tbl[2] = '{exc:1, intr:1, ec:5'd11, addr:32'h8000_0100, insn:32'h1234_0001,
               tval:32'h0BAD_F00D, exp_hdr:32'hA970_0002, exp_n:4};
    tbl[3] = '{exc:0, intr:0, ec:5'd7,  addr:32'h1234_5678, insn:32'hFFFF_FFFF,
               tval:32'h5555_AAAA, exp_hdr:32'hA00C_0003, exp_n:3};

    // Directed single-record table
    do_reset();
    tx_ready = 1'b1;
    trace_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cap.delete();
      cap_cyc.delete();
      set_pkt(1, tbl[i].exc, tbl[i].intr, tbl[i].ec, tbl[i].addr, tbl[i].insn, tbl[i].tval);
      pc = cyc;
      cycle();
      trace_pkt = '0;
      run_until_idle(30);
      check($sformatf("tbl%0d_nbeats", i), 32'(cap.size()), 32'(tbl[i].exp_n));
      check($sformatf("tbl%0d_hdr", i), capk(0), tbl[i].exp_hdr);
      check($sformatf("tbl%0d_addr", i), capk(1), tbl[i].addr);
      check($sformatf("tbl%0d_insn", i), capk(2), tbl[i].insn);
      if (tbl[i].exp_n == 4) check($sformatf("tbl%0d_tval", i), capk(3), tbl[i].tval);
      check($sformatf("tbl%0d_latency", i),
            32'((cap_cyc.size() > 0) ? cap_cyc[0] - pc : -1), 32'd2);
    end

    // Stall for 5 cycles on the ADDR beat
    do_reset();
    tx_ready = 1'b1;
    trace_en = 1'b1;
    set_pkt(1, 1, 0, 5'd2, 32'h0000_0100, 32'h0000_0200, 32'hDEAD_BEEF);
    cycle();
    trace_pkt = '0;
    cycle();
    cycle();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_data", tx_data, 32'h0000_0100);
      check("stall_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    run_until_idle(30);
    check("stall_nbeats", 32'(cap.size()), 32'd4);
    check("stall_hdr", capk(0), 32'hA450_0000);
    check("stall_addr", capk(1), 32'h0000_0100);
    check("stall_insn", capk(2), 32'h0000_0200);
    check("stall_tval", capk(3), 32'hDEAD_BEEF);

    // Overflow: 7 packets into a stalled 4-deep FIFO, then a marker
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_pkt(1, 0, 0, 5'd0, 32'h100 + 32'(i), 32'h13, 32'h0);
      cycle();
    end
    trace_pkt = '0;
    cycle();
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    tx_ready = 1'b1;
    k = 0;
    while (mq.size() >= DEPTH && k < 20) begin
      cycle();
      k++;
    end
    if (k == 20) check("ovf_slot_timeout", 32'd1, 32'd0);
    set_pkt(1, 0, 0, 5'd0, 32'h200, 32'h13, 32'h0);
    cycle();
    trace_pkt = '0;
    check("ovf_drop_clr", 32'(drop_cnt), 32'd0);
    run_until_idle(100);
    check("ovf_nbeats", 32'(cap.size()), 32'd13);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_rec%0d_hdr", i), capk(3 * i), 32'hA00C_0000 + 32'(i));
    check("ovf_marker", capk(12), 32'hAC04_0004);

    // Sequence wrap
    do_reset();
    tx_ready = 1'b1;
    trace_en = 1'b1;
    for (int i = 0; i < (1 << SEQ_W) + 1; i++) begin
      set_pkt(1, 0, 0, 5'd0, 32'(i), 32'h13, 32'h0);
      cycle();
      trace_pkt = '0;
      cycle();
      cycle();
    end
    run_until_idle(50);
    check("wrap_nbeats", 32'(cap.size()), 32'(3 * ((1 << SEQ_W) + 1)));
    check("wrap_last_hdr", capk(3 * ((1 << SEQ_W) - 1)), 32'hA00C_0000 + 32'((1 << SEQ_W) - 1));
    check("wrap_zero_hdr", capk(3 * (1 << SEQ_W)), 32'hA00C_0000);

    // Reset during the INSN beat, with drops outstanding
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_pkt(1, 0, 0, 5'd0, 32'h300 + 32'(i), 32'h0000_0033, 32'h0);
      cycle();
    end
    trace_pkt = '0;
    cycle();
    check("rstmid_drop_cnt", 32'(drop_cnt), 32'd2);
    tx_ready = 1'b1;
    k = 0;
    while (!(m_active && m_idx == 2) && k < 20) begin
      cycle();
      k++;
    end
    if (k == 20) check("rstmid_timeout", 32'd1, 32'd0);
    @(negedge clk);
    check("rstmid_insn", tx_data, 32'h0000_0033);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid_valid", 32'(tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap.delete();
    cap_cyc.delete();
    set_pkt(1, 0, 0, 5'd0, 32'h400, 32'h13, 32'h0);
    cycle();
    trace_pkt = '0;
    run_until_idle(30);
    check("rstmid_seq0_hdr", capk(0), 32'hA00C_0000);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      trace_en = ($urandom_range(9) != 0);
      set_pkt($urandom_range(9) < 6, $urandom_range(3) == 0, $urandom_range(5) == 0,
              5'($urandom), $urandom, $urandom, $urandom);
      tx_ready = ($urandom_range(9) < 7);
      cycle();
    end
    trace_pkt = '0;
    trace_en  = 1'b0;
    tx_ready  = 1'b1;
    run_until_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
